// File: rtl/tl_pkg.sv
// Transaction-layer shared definitions.
// Word layout used by every lane FIFO and by the arbiter: {dest, data}.
// Also carries the FIFO status flag bundle and field-slice helpers.
package tl_pkg;

    localparam int DATA_W = 8;
    localparam int DEST_W = 4;
    localparam int WORD_W = DATA_W + DEST_W;
    localparam int LANES  = 4;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{empty: 1'b1, full: 1'b0,
                                           almost_empty: 1'b1, almost_full: 1'b0};

    function automatic logic [DEST_W-1:0] word_dest(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] w);
        return w[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_vc_if.sv
// Lane FIFO bus: producer/consumer handshake and status.
// master : drives push/data_in/pop/thresholds, observes read data and flags.
// slave  : the FIFO itself.
interface fifo_vc_if
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [ADDR_WIDTH:0]   thr_almost_full;
    logic [ADDR_WIDTH:0]   thr_almost_empty;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  error;

    modport master (
        output push, data_in, pop, thr_almost_full, thr_almost_empty,
        input  data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );

    modport slave (
        input  push, data_in, pop, thr_almost_full, thr_almost_empty,
        output data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register file, 2**ADDR_WIDTH x DATA_WIDTH.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (read register only)
//   wr_en_i/addr/data   - synchronous write port
//   rd_en_i/rd_addr_i   - synchronous read request
//   rd_data_o           - registered read data, holds when rd_en_i is low
// Storage is not cleared by reset. A read and write to the same address in
// one cycle returns the old contents.
module fifo_mem
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_vc.sv
// Per-lane input FIFO ahead of the transaction-layer arbiter.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - fifo_vc_if.slave: push/data_in/pop/thresholds in;
//           data_out/valid_out/count/empty/full/almost_*/error out
// All outputs are registered; flags describe occupancy after the edge.
module fifo_vc
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    fifo_vc_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  valid_q;
    logic                  error_q, error_d;
    logic                  acc_push, acc_pop;

    // A push into a full FIFO is legal only when a pop frees the slot at the
    // same edge; the read sees the old word since write and read share an edge.
    assign acc_pop  = bus.pop && !flags_q.empty;
    assign acc_push = bus.push && (!flags_q.full || acc_pop);

    always_comb begin
        count_d               = count_q + CW'(acc_push) - CW'(acc_pop);
        flags_d.empty         = (count_d == '0);
        flags_d.full          = (count_d == CW'(DEPTH));
        flags_d.almost_empty  = (count_d <= bus.thr_almost_empty);
        flags_d.almost_full   = (count_d >= bus.thr_almost_full);
        // Overflow: dropped push. Underflow: lone pop on empty (a pop paired
        // with a push is simply ignored).
        error_d = error_q
                | (bus.push && flags_q.full && !acc_pop)
                | (bus.pop && flags_q.empty && !bus.push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_RESET;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (acc_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (acc_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            flags_q <= flags_d;
            valid_q <= acc_pop;
            error_q <= error_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (acc_push && !reset),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_in),
        .rd_en_i   (acc_pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.data_out)
    );

    assign bus.valid_out    = valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = flags_q.empty;
    assign bus.full         = flags_q.full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_vc.sv
// Directed bench for fifo_vc (depth 4, 12-bit words).
module tb_fifo_vc;
    import tl_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fifo_vc_if #(.DATA_WIDTH(12), .ADDR_WIDTH(2)) bus ();

    fifo_vc #(.DATA_WIDTH(12), .ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ps, input logic pp, input logic [11:0] d);
        bus.push    = ps;
        bus.pop     = pp;
        bus.data_in = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 12'hFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if (bus.count !== 3'd0) begin $display("FAIL reset_count got %0d exp 0", bus.count); n_fail++; end
        n_checks++;
        if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
            $display("FAIL reset_flags got %b exp 1010", {bus.empty, bus.full, bus.almost_empty, bus.almost_full}); n_fail++;
        end
        n_checks++;
        if ({bus.valid_out, bus.error} !== 2'b00) begin
            $display("FAIL reset_valid_err got %b exp 00", {bus.valid_out, bus.error}); n_fail++;
        end
        n_checks++;
        if (bus.data_out !== 12'h000) begin $display("FAIL reset_data got %h exp 000", bus.data_out); n_fail++; end
    endtask

    // Push A01..D04 with thr_almost_full=3, thr_almost_empty=1.
    task automatic test_fill();
        logic [11:0] w [4];
        w[0] = 12'hA01; w[1] = 12'hB02; w[2] = 12'hC03; w[3] = 12'hD04;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, w[i]);
            tick();
            n_checks++;
            if (bus.count !== 3'(i + 1)) begin $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i + 1); n_fail++; end
            n_checks++;
            if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== {1'b0, i == 3, i == 0, i >= 2}) begin
                $display("FAIL fill_flags[%0d] got %b exp %b", i,
                         {bus.empty, bus.full, bus.almost_empty, bus.almost_full}, {1'b0, i == 3, i == 0, i >= 2});
                n_fail++;
            end
            n_checks++;
            if (bus.error !== 1'b0) begin $display("FAIL fill_error[%0d] got %b exp 0", i, bus.error); n_fail++; end
        end
        drive(1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_overflow();
        logic [11:0] w [4];
        w[0] = 12'hA01; w[1] = 12'hB02; w[2] = 12'hC03; w[3] = 12'hD04;
        drive(1'b1, 1'b0, 12'hEEE);
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.count, bus.full, bus.error} !== {3'd4, 1'b1, 1'b1}) begin
            $display("FAIL ovf_state got cnt=%0d full=%b err=%b exp cnt=4 full=1 err=1", bus.count, bus.full, bus.error); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            tick();
            n_checks++;
            if ({bus.valid_out, bus.data_out} !== {1'b1, w[i]}) begin
                $display("FAIL ovf_pop[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.valid_out, bus.data_out, w[i]); n_fail++;
            end
            n_checks++;
            if ({bus.count, bus.error} !== {3'(3 - i), 1'b1}) begin
                $display("FAIL ovf_cnt[%0d] got cnt=%0d err=%b exp cnt=%0d err=1", i, bus.count, bus.error, 3 - i); n_fail++;
            end
        end
        drive(1'b0, 1'b0, 12'h000);
        tick();
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.empty} !== {1'b0, 12'hD04, 1'b1}) begin
            $display("FAIL ovf_idle got v=%b d=%h e=%b exp v=0 d=D04 e=1", bus.valid_out, bus.data_out, bus.empty); n_fail++;
        end
    endtask

    // Runs with error already sticky from the overflow scenario.
    task automatic test_empty_push_pop();
        drive(1'b1, 1'b1, 12'h055);
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.valid_out, bus.count, bus.empty, bus.error} !== {1'b0, 3'd1, 1'b0, 1'b1}) begin
            $display("FAIL epp_state got v=%b cnt=%0d e=%b err=%b exp v=0 cnt=1 e=0 err=1",
                     bus.valid_out, bus.count, bus.empty, bus.error); n_fail++;
        end
        drive(1'b0, 1'b1, 12'h000);
        tick();
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.count} !== {1'b1, 12'h055, 3'd0}) begin
            $display("FAIL epp_pop got v=%b d=%h cnt=%0d exp v=1 d=055 cnt=0", bus.valid_out, bus.data_out, bus.count); n_fail++;
        end
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.count} !== {1'b0, 12'h055, 3'd0}) begin
            $display("FAIL epp_underflow got v=%b d=%h cnt=%0d exp v=0 d=055 cnt=0", bus.valid_out, bus.data_out, bus.count); n_fail++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [11:0] w [4];
        w[0] = 12'hB02; w[1] = 12'hC03; w[2] = 12'hD04; w[3] = 12'h123;
        drive(1'b1, 1'b1, 12'h123);
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.count, bus.full, bus.error} !== {1'b1, 12'hA01, 3'd4, 1'b1, 1'b0}) begin
            $display("FAIL fpp_state got v=%b d=%h cnt=%0d f=%b err=%b exp v=1 d=A01 cnt=4 f=1 err=0",
                     bus.valid_out, bus.data_out, bus.count, bus.full, bus.error); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            tick();
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.error} !== {1'b1, w[i], 1'b0}) begin
                $display("FAIL fpp_pop[%0d] got v=%b d=%h err=%b exp v=1 d=%h err=0",
                         i, bus.valid_out, bus.data_out, bus.error, w[i]); n_fail++;
            end
        end
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if (bus.empty !== 1'b1) begin $display("FAIL fpp_empty got %b exp 1", bus.empty); n_fail++; end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 12'(i));
            tick();
            if (bus.count !== 3'd1) bad++;
            drive(1'b0, 1'b1, 12'h000);
            tick();
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.count} !== {1'b1, 12'(i), 3'd0}) begin
                $display("FAIL wrap_pop[%0d] got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=0",
                         i, bus.valid_out, bus.data_out, bus.count, 12'(i)); n_fail++;
            end
        end
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if (bad !== 0) begin $display("FAIL wrap_count got %0d bad samples exp 0", bad); n_fail++; end
        n_checks++;
        if (bus.error !== 1'b0) begin $display("FAIL wrap_error got %b exp 0", bus.error); n_fail++; end
    endtask

    // Thresholds are live: changes show at the next edge with no push/pop.
    task automatic test_thresholds();
        drive(1'b1, 1'b0, 12'h201); tick();
        drive(1'b1, 1'b0, 12'h202); tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.almost_empty, bus.almost_full} !== 2'b00) begin
            $display("FAIL thr_before got ae=%b af=%b exp 00", bus.almost_empty, bus.almost_full); n_fail++;
        end
        bus.thr_almost_full  = 3'd2;
        bus.thr_almost_empty = 3'd2;
        tick();
        n_checks++;
        if ({bus.almost_empty, bus.almost_full} !== 2'b11) begin
            $display("FAIL thr_after got ae=%b af=%b exp 11", bus.almost_empty, bus.almost_full); n_fail++;
        end
        bus.thr_almost_full  = 3'd3;
        bus.thr_almost_empty = 3'd1;
        tick();
    endtask

    // Entered with two words queued; adds one more then resets.
    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 12'h203);
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if (bus.count !== 3'd3) begin $display("FAIL mr_pre_count got %0d exp 3", bus.count); n_fail++; end
        drive(1'b1, 1'b1, 12'h3FF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.count, bus.empty, bus.almost_empty, bus.almost_full, bus.valid_out, bus.error}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL mr_state got cnt=%0d e=%b ae=%b af=%b v=%b err=%b exp cnt=0 e=1 ae=1 af=0 v=0 err=0",
                     bus.count, bus.empty, bus.almost_empty, bus.almost_full, bus.valid_out, bus.error); n_fail++;
        end
        drive(1'b0, 1'b1, 12'h000);
        tick();
        n_checks++;
        if ({bus.valid_out, bus.count} !== {1'b0, 3'd0}) begin
            $display("FAIL mr_pop_ignored got v=%b cnt=%0d exp v=0 cnt=0", bus.valid_out, bus.count); n_fail++;
        end
        drive(1'b1, 1'b0, 12'h777);
        tick();
        drive(1'b0, 1'b1, 12'h000);
        tick();
        drive(1'b0, 1'b0, 12'h000);
        n_checks++;
        if ({bus.valid_out, bus.data_out} !== {1'b1, 12'h777}) begin
            $display("FAIL mr_repush got v=%b d=%h exp v=1 d=777", bus.valid_out, bus.data_out); n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.thr_almost_full  = 3'd3;
        bus.thr_almost_empty = 3'd1;
        drive(1'b0, 1'b0, 12'h000);
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_empty_push_pop();
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_thresholds();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_vc.md
# fifo_vc

Per-channel input FIFO that buffers transaction words ahead of the four-lane arbiter in the transaction layer. Each instance stores words of {dest[3:0], data[7:0]}, delivers them one per pop with a registered output, and reports empty, full, almost_empty and almost_full so the producer can be throttled and the arbiter knows when a lane has work. Four instances, one per lane, feed the arbiter's data_in0..3 / dest_in0..3 and its per-lane empty inputs.

## Interface
Parameters:
- DATA_WIDTH, 12: word width. Bits [11:8] are dest and bits [7:0] are data.
- ADDR_WIDTH, 2: depth is 2**ADDR_WIDTH, so 4 by default.

Ports:
- clk  in  1: single clock. Every register updates on the rising edge.
- reset  in  1: synchronous, active-high reset.
- push  in  1: write request, sampled at the rising edge.
- data_in  in  DATA_WIDTH: word to write when push is sampled.
- pop  in  1: read request, sampled at the rising edge.
- thr_almost_full  in  ADDR_WIDTH+1: almost_full threshold. Range 1..DEPTH.
- thr_almost_empty  in  ADDR_WIDTH+1: almost_empty threshold. Range 0..DEPTH-1.
- data_out  out  DATA_WIDTH: registered read word.
- valid_out  out  1: data_out carries a word popped at the previous edge.
- count  out  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- empty  out  1: count == 0.
- full  out  1: count == DEPTH.
- almost_empty  out  1: count <= thr_almost_empty.
- almost_full  out  1: count >= thr_almost_full.
- error  out  1: sticky flag for overflow or underflow.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each ADDR_WIDTH bits. Pointers wrap naturally from DEPTH-1 to 0. Occupancy is held in an explicit count register of ADDR_WIDTH+1 bits, so full and empty are never ambiguous.
- Accepted push: push && (!full || pop_accepted). Writes mem[wr_ptr] and increments wr_ptr.
- Accepted pop: pop && !empty. Loads data_out <= mem[rd_ptr], increments rd_ptr, and sets valid_out=1 for the next cycle.
- Without an accepted pop, valid_out=0 and data_out holds its last value.
- Count update: count_next = count + acc_push - acc_pop.
- Flags: all flags are registered and computed from count_next, so they describe the occupancy after the edge.
- Boundary cases:
  - push while full, no pop: the word is dropped, error is set, and pointers and count are unchanged.
  - push && pop while full: both are accepted. count stays at DEPTH and the popped word is the oldest one.
  - pop while empty, with or without push: the pop is ignored and valid_out=0. There is no bypass. A push in the same cycle is still accepted.
  - pop while empty, without push: error is also set.
  - push && pop while both are legal: both are accepted and count is unchanged.
- error stays at 1 until reset.
- Thresholds are sampled live. A change to a threshold takes effect at the next edge.
- Reset (synchronous, also mid-operation): count=0, wr_ptr=0, rd_ptr=0, data_out=0, valid_out=0, empty=1, full=0, almost_empty=1, almost_full=0, error=0. Memory contents are not cleared. Push and pop in the reset cycle are ignored.

## Timing
- Read latency is 1 cycle: pop sampled at edge N gives data_out and valid_out valid after edge N, stable for cycle N+1.
- Write-to-readable latency is 1 cycle: a word pushed at edge N can be popped at edge N+1 at the earliest.
- Flags and count are updated at the same edge as the push or pop that changes them.
- There are no combinational paths from push/pop to any output.
- Producer rule: the producer must not push while full unless a pop is issued in the same cycle. Violating this sets error.

## Structure
- A shared package, tl_pkg, holds:
  - DATA_W=8 and DEST_W=4.
  - WORD_W = DATA_W + DEST_W.
  - Field-slice helpers for dest and data.
  - LANES=4.
- One sub-module, fifo_mem: a simple dual-port register file, DEPTH x DATA_WIDTH, with a synchronous write port and a registered synchronous read port.
- fifo_vc contains the pointers, count, flags, error and the control logic.

## Test plan
- Reset, then push 12'hA01, 12'hB02, 12'hC03, 12'hD04 on consecutive edges with thr_almost_full=3 → count goes 1,2,3,4; almost_full rises after the 3rd push; full=1 after the 4th; error=0.
- From full, push 12'hEEE alone → word dropped, count=4, error=1 and it stays 1. Then pop 4 times → data_out returns A01, B02, C03, D04 in order, each with valid_out=1 one cycle after its pop.
- From full, push 12'h123 and pop together → data_out=12'hA01, count stays 4. The fourth following pop returns 12'h123, and error stays 0.
- From empty, push 12'h055 and pop together → valid_out=0, count=1, error=1. The next pop returns 12'h055.
- Wrap-around: perform 10 interleaved push/pop pairs with values 12'h000..12'h009 → output order preserved, count never exceeds 1, no error.
- Assert reset with count=3 mid-stream → count=0, empty=1, almost_empty=1, almost_full=0, valid_out=0, error=0. A later pop is ignored until a new push.
